// File: rtl/csr_access_ctrl.sv
// CSR access controller: arbitrates core/debug CSR requests (debug first) and runs
// each one as a read-modify-write with a 4-cycle sequence IDLE -> READ -> WRITE -> RESP.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module csr_access_ctrl #(
    parameter int WIDTH    = `WORD_SIZE,
    parameter int RO_CHECK = 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_core_valid,
    output logic             o_core_ready,
    input  logic [11:0]      i_core_addr,
    input  logic [2:0]       i_core_funct3,
    input  logic [WIDTH-1:0] i_core_src,
    input  logic             i_core_src_zero,
    input  logic             i_dbg_valid,
    output logic             o_dbg_ready,
    input  logic [11:0]      i_dbg_addr,
    input  logic [2:0]       i_dbg_funct3,
    input  logic [WIDTH-1:0] i_dbg_src,
    input  logic             i_dbg_src_zero,
    output logic [11:0]      o_csr_addr,
    input  logic [WIDTH-1:0] i_csr_rd,
    output logic [WIDTH-1:0] o_csr_wd,
    output logic             o_csr_en,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_rdata,
    output logic             o_rsp_err,
    output logic [1:0]       o_fsm_state
);

    // Handshake: a request transfers on a rising edge where valid and ready are both 1;
    // ready is only ever high in IDLE, so holding valid afterwards has no effect.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [11:0]      r_addr;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_src;
    logic             r_src_zero;
    logic             r_id;
    logic [WIDTH-1:0] r_old;
    logic             r_err;

    logic             w_grant_dbg;
    logic             w_grant_core;
    logic [1:0]       w_op;
    logic             w_bad_op;
    logic             w_writes;
    logic             w_illegal;
    logic [WIDTH-1:0] w_new;

    // Readies are gated by reset so they read 0 while i_rstn is low.
    assign w_grant_dbg  = i_rstn && (r_state == S_IDLE) && i_dbg_valid;
    assign w_grant_core = i_rstn && (r_state == S_IDLE) && i_core_valid && !i_dbg_valid;

    assign w_op      = r_funct3[1:0];
    assign w_bad_op  = (w_op == 2'b00);
    assign w_writes  = !w_bad_op && ((w_op == 2'b01) || !r_src_zero);
    assign w_illegal = w_bad_op ||
                       ((RO_CHECK != 0) && (r_addr[11:10] == 2'b11) && w_writes);

    always_comb begin
        w_new = '0;
        case (w_op)
            2'b01:   w_new = r_src;
            2'b10:   w_new = r_old | r_src;
            2'b11:   w_new = r_old & ~r_src;
            default: w_new = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_src      <= '0;
            r_src_zero <= 1'b0;
            r_id       <= 1'b0;
            r_old      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant_dbg) begin
                r_addr     <= i_dbg_addr;
                r_funct3   <= i_dbg_funct3;
                r_src      <= i_dbg_src;
                r_src_zero <= i_dbg_src_zero;
                r_id       <= 1'b1;
            end else if (w_grant_core) begin
                r_addr     <= i_core_addr;
                r_funct3   <= i_core_funct3;
                r_src      <= i_core_src;
                r_src_zero <= i_core_src_zero;
                r_id       <= 1'b0;
            end
            if (r_state == S_READ) r_old <= i_csr_rd;
            if (r_state == S_WRITE) r_err <= w_illegal;
        end
    end

    always_comb begin
        w_next       = S_IDLE;
        o_core_ready = 1'b0;
        o_dbg_ready  = 1'b0;
        o_csr_addr   = '0;
        o_csr_wd     = '0;
        o_csr_en     = 1'b0;
        o_rsp_valid  = 1'b0;
        o_rsp_id     = 1'b0;
        o_rsp_rdata  = '0;
        o_rsp_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_dbg_ready  = w_grant_dbg;
                o_core_ready = w_grant_core;
                w_next       = (w_grant_dbg || w_grant_core) ? S_READ : S_IDLE;
            end
            S_READ: begin
                o_csr_addr = r_addr;
                w_next     = S_WRITE;
            end
            S_WRITE: begin
                o_csr_addr = r_addr;
                o_csr_en   = w_writes && !w_illegal;
                o_csr_wd   = (w_writes && !w_illegal) ? w_new : '0;
                w_next     = S_RESP;
            end
            S_RESP: begin
                o_csr_addr  = r_addr;
                o_rsp_valid = 1'b1;
                o_rsp_id    = r_id;
                o_rsp_err   = r_err;
                o_rsp_rdata = r_err ? '0 : r_old;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: vector table plus random vectors through a response
// scoreboard, and hand-written sequences for arbitration and mid-operation reset.
module tb_csr_access_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          core_valid, core_ready, core_src_zero;
    logic [11:0]   core_addr;
    logic [2:0]    core_funct3;
    logic [W-1:0]  core_src;
    logic          dbg_valid, dbg_ready, dbg_src_zero;
    logic [11:0]   dbg_addr;
    logic [2:0]    dbg_funct3;
    logic [W-1:0]  dbg_src;
    logic [11:0]   csr_addr;
    logic [W-1:0]  csr_val, csr_wd, rsp_rdata;
    logic          csr_en, rsp_valid, rsp_id, rsp_err;
    logic [1:0]    fsm_state;

    always #5 clk = ~clk;

    csr_access_ctrl #(.WIDTH(W), .RO_CHECK(1)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_core_valid(core_valid), .o_core_ready(core_ready), .i_core_addr(core_addr),
        .i_core_funct3(core_funct3), .i_core_src(core_src), .i_core_src_zero(core_src_zero),
        .i_dbg_valid(dbg_valid), .o_dbg_ready(dbg_ready), .i_dbg_addr(dbg_addr),
        .i_dbg_funct3(dbg_funct3), .i_dbg_src(dbg_src), .i_dbg_src_zero(dbg_src_zero),
        .o_csr_addr(csr_addr), .i_csr_rd(csr_val), .o_csr_wd(csr_wd), .o_csr_en(csr_en),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_fsm_state(fsm_state)
    );

    typedef struct {
        logic         dbg;
        logic [11:0]  addr;
        logic [2:0]   f3;
        logic [W-1:0] src;
        logic         sz;
        logic [W-1:0] csr;
        logic         exp_en;
        logic [W-1:0] exp_wd;
        logic [W-1:0] exp_rdata;
        logic         exp_err;
    } vec_t;

    // Record layout: {id, err, en, wd[63:32], rdata[31:0]}
    logic [2*W+2:0] exp_q[$];
    logic           en_seen = 1'b0;
    int             n_checks = 0;
    int             n_pass = 0;
    vec_t           vecs[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic dbg, input logic [11:0] addr, input logic [2:0] f3,
                                input logic [W-1:0] src, input logic sz, input logic [W-1:0] csr,
                                input logic en, input logic [W-1:0] wd, input logic [W-1:0] rd,
                                input logic err);
        vec_t v;
        v.dbg = dbg; v.addr = addr; v.f3 = f3; v.src = src; v.sz = sz; v.csr = csr;
        v.exp_en = en; v.exp_wd = wd; v.exp_rdata = rd; v.exp_err = err;
        return v;
    endfunction

    // Reference behaviour for random vectors.
    function automatic vec_t model(input logic dbg, input logic [11:0] addr, input logic [2:0] f3,
                                   input logic [W-1:0] src, input logic sz, input logic [W-1:0] csr);
        logic bad, wr, ill, en;
        logic [W-1:0] wd;
        bad = (f3 == 3'b000) || (f3 == 3'b100);
        wr  = !bad && (f3 == 3'b001 || f3 == 3'b101 || !sz);
        ill = bad || (addr >= 12'hC00 && wr);
        en  = wr && !ill;
        wd  = '0;
        if (en) begin
            if (f3 == 3'b001 || f3 == 3'b101) wd = src;
            else if (f3 == 3'b010 || f3 == 3'b110) wd = csr | src;
            else wd = csr & ~src;
        end
        return mk(dbg, addr, f3, src, sz, csr, en, wd, ill ? '0 : csr, ill);
    endfunction

    always @(negedge clk) begin
        if (csr_en) begin
            if (exp_q.size() == 0) check("unexpected_csr_en", 64'd1, 64'd0);
            else begin
                check("csr_en_expected", 64'd1, {63'd0, exp_q[0][2*W]});
                check("csr_wd", {32'd0, csr_wd}, {32'd0, exp_q[0][2*W-1:W]});
                en_seen = 1'b1;
            end
        end
        if (rsp_valid) begin
            if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
            else begin
                logic [2*W+2:0] e;
                e = exp_q.pop_front();
                check("rsp_id", {63'd0, rsp_id}, {63'd0, e[2*W+2]});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e[2*W+1]});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e[W-1:0]});
                check("en_seen", {63'd0, en_seen}, {63'd0, e[2*W]});
                en_seen = 1'b0;
            end
        end
    end

    task automatic drive_req(input vec_t v);
        if (v.dbg) begin
            dbg_addr = v.addr; dbg_funct3 = v.f3; dbg_src = v.src; dbg_src_zero = v.sz;
            dbg_valid = 1'b1;
        end else begin
            core_addr = v.addr; core_funct3 = v.f3; core_src = v.src; core_src_zero = v.sz;
            core_valid = 1'b1;
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_q.push_back({v.dbg, v.exp_err, v.exp_en, v.exp_wd, v.exp_rdata});
    endtask

    task automatic scramble();
        logic [31:0] r;
        core_valid = 1'b0; dbg_valid = 1'b0;
        r = $urandom; core_addr = r[11:0]; dbg_addr = r[23:12]; core_funct3 = r[26:24];
        dbg_funct3 = r[29:27]; core_src_zero = r[30]; dbg_src_zero = r[31];
        core_src = $urandom; dbg_src = $urandom;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic granted;
        granted = 1'b0;
        @(negedge clk);
        csr_val = v.csr;
        drive_req(v);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (v.dbg ? dbg_ready : core_ready) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({nm, "_grant"}, {63'd0, granted}, 64'd1);
        if (!granted) begin
            scramble();
            return;
        end
        push_exp(v);
        @(posedge clk);
        #1 scramble();
        @(negedge clk);
        check({nm, "_read_state"}, {62'd0, fsm_state}, 64'd1);
        check({nm, "_read_addr"}, {52'd0, csr_addr}, {52'd0, v.addr});
        @(negedge clk);
        check({nm, "_write_en"}, {63'd0, csr_en}, {63'd0, v.exp_en});
        @(negedge clk);
        check({nm, "_rsp_at_n3"}, {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_ctl"}, {54'd0, core_ready, dbg_ready, csr_en, rsp_valid, rsp_id, rsp_err,
               fsm_state, 2'b00}, 64'd0);
        check({nm, "_data"}, {rsp_rdata, csr_wd} | {52'd0, csr_addr}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t cv, dv;
        logic [31:0] r;
        rstn = 1'b0; csr_val = '0;
        scramble();
        core_valid = 1'b1; dbg_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        core_valid = 1'b0; dbg_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1 check("idle_after_reset", {62'd0, fsm_state}, 64'd0);

        vecs[0]  = mk(0, 12'h300, 3'b010, 32'h80, 0, 32'h8, 1, 32'h88, 32'h8, 0);
        vecs[1]  = mk(0, 12'h305, 3'b001, 32'h12345678, 0, 32'hDEADBEEF, 1, 32'h12345678, 32'hDEADBEEF, 0);
        vecs[2]  = mk(0, 12'h341, 3'b011, 32'h0F0F0F0F, 0, 32'hFFFF00FF, 1, 32'hF0F000F0, 32'hFFFF00FF, 0);
        vecs[3]  = mk(0, 12'h341, 3'b011, 32'h0, 1, 32'h80000004, 0, 32'h0, 32'h80000004, 0);
        vecs[4]  = mk(1, 12'h7B0, 3'b101, 32'h1F, 0, 32'h40000003, 1, 32'h1F, 32'h40000003, 0);
        vecs[5]  = mk(0, 12'h300, 3'b110, 32'h5, 0, 32'hA, 1, 32'hF, 32'hA, 0);
        vecs[6]  = mk(0, 12'h300, 3'b111, 32'h3, 0, 32'hF, 1, 32'hC, 32'hF, 0);
        vecs[7]  = mk(0, 12'hF11, 3'b001, 32'h55, 0, 32'h11, 0, 32'h0, 32'h0, 1);
        vecs[8]  = mk(0, 12'hF11, 3'b010, 32'h0, 1, 32'h11, 0, 32'h0, 32'h11, 0);
        vecs[9]  = mk(0, 12'h300, 3'b000, 32'h1, 0, 32'h22, 0, 32'h0, 32'h0, 1);
        vecs[10] = mk(1, 12'h7B1, 3'b100, 32'h1, 0, 32'h33, 0, 32'h0, 32'h0, 1);
        vecs[11] = mk(0, 12'hC00, 3'b001, 32'h0, 1, 32'h44, 0, 32'h0, 32'h0, 1);
        vecs[12] = mk(0, 12'hBFF, 3'b101, 32'h7, 0, 32'h0, 1, 32'h7, 32'h0, 0);
        vecs[13] = mk(0, 12'hC00, 3'b110, 32'h1, 0, 32'h66, 0, 32'h0, 32'h0, 1);
        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 10; i++) begin
            logic sz;
            logic [W-1:0] src;
            r   = $urandom;
            sz  = r[15];
            src = sz ? '0 : $urandom_range(1, 32'hFFFF_FFFF);
            run_vec(model(r[16], r[11:0], r[14:12], src, sz, $urandom), $sformatf("rnd%0d", i));
        end

        // Simultaneous requests: debug wins, core follows after the debug response.
        @(negedge clk);
        csr_val = 32'h5;
        dv = mk(1, 12'h7B1, 3'b010, 32'h2, 0, 32'h5, 1, 32'h7, 32'h5, 0);
        cv = mk(0, 12'h340, 3'b001, 32'h99, 0, 32'h5, 1, 32'h99, 32'h5, 0);
        drive_req(dv);
        drive_req(cv);
        #1;
        check("arb_dbg_ready", {63'd0, dbg_ready}, 64'd1);
        check("arb_core_ready", {63'd0, core_ready}, 64'd0);
        push_exp(dv);
        @(posedge clk);
        #1 dbg_valid = 1'b0;
        @(negedge clk);
        check("arb_core_wait_read", {63'd0, core_ready}, 64'd0);
        repeat (2) @(negedge clk);
        check("arb_dbg_rsp", {62'd0, rsp_valid, rsp_id}, 64'd3);
        check("arb_core_wait_resp", {63'd0, core_ready}, 64'd0);
        @(negedge clk);
        check("arb_core_ready_after", {63'd0, core_ready}, 64'd1);
        push_exp(cv);
        @(posedge clk);
        #1 scramble();
        repeat (3) @(negedge clk);
        check("arb_core_rsp", {62'd0, rsp_valid, rsp_id}, 64'd2);

        // Reset during WRITE aborts the access with no write and no response.
        @(negedge clk);
        csr_val = 32'h0;
        cv = mk(0, 12'h340, 3'b001, 32'hAA, 0, 32'h0, 1, 32'hAA, 32'h0, 0);
        drive_req(cv);
        #1 check("abort_grant", {63'd0, core_ready}, 64'd1);
        @(posedge clk);
        #1 core_valid = 1'b0;
        @(posedge clk);
        #2;
        check("abort_in_write", {62'd0, fsm_state}, 64'd2);
        rstn = 1'b0;
        core_valid = 1'b1; dbg_valid = 1'b1;
        #1 check_outputs_zero("abort_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", {62'd0, rsp_valid, csr_en}, 64'd0);
        end
        en_seen = 1'b0;
        scramble();
        @(negedge clk);
        rstn = 1'b1;
        run_vec(mk(0, 12'h300, 3'b010, 32'h80, 0, 32'h8, 1, 32'h88, 32'h8, 0), "post_reset");

        repeat (6) @(negedge clk);
        check("queue_drained", {32'd0, exp_q.size()}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
